// File: rtl/spi_pkg.sv
// Shared types and sizing constants for the SPI serf and its synchronizers.
package spi_pkg;
  localparam int SPI_DATA_W      = 16;
  localparam int SPI_SYNC_STAGES = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } serf_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous SPI pin, exposing the ff2 level
// plus rise/fall strobes derived from ff2 versus ff3.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_reg;
  logic [SPI_SYNC_STAGES-1:0] vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SPI_SYNC_STAGES{RST_VAL}};
      vld_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[SPI_SYNC_STAGES-2:0], d};
      vld_reg  <= {vld_reg[SPI_SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edges are reported only once the whole chain holds post-reset samples, so
  // a pin already away from RST_VAL at reset release produces no phantom edge.
  assign level = sync_reg[1];
  assign rise  = vld_reg[SPI_SYNC_STAGES-1] &  sync_reg[1] & ~sync_reg[2];
  assign fall  = vld_reg[SPI_SYNC_STAGES-1] & ~sync_reg[1] &  sync_reg[2];

endmodule

// File: rtl/spi_serf.sv
// SPI responder: samples MOSI and shifts MISO on synchronized SCLK rises
// (SCLK idles high, MSB first) and hands each complete frame to local logic.
module spi_serf
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wrt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              clr_rdy,
  output logic              rdy,
  output logic [DATA_W-1:0] rx_data,
  output logic              frm_err
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  serf_state_t       state_reg, state_next;
  logic [DATA_W-1:0] shft_reg, shft_next;
  logic [DATA_W-1:0] tx_hold_reg;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              load_frame, capture, err;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .d(SS_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(SCLK),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .d(MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A shift coinciding with ss_rise lands first, so the frame check and the
  // captured word both use the post-shift values.
  always_comb begin
    state_next   = state_reg;
    shft_next    = shft_reg;
    bit_cnt_next = bit_cnt_reg;
    load_frame   = 1'b0;
    capture      = 1'b0;
    err          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          load_frame = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shft_next = {shft_reg[DATA_W-2:0], mosi_lvl};
          if (bit_cnt_reg != '1) bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end
        if (ss_rise) begin
          state_next = IDLE;
          if (bit_cnt_next == FULL_CNT) capture = 1'b1;
          else                          err     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold_reg <= '0;
      shft_reg    <= '0;
      bit_cnt_reg <= '0;
      rx_data     <= '0;
      rdy         <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      if (wrt) tx_hold_reg <= tx_data;
      if (load_frame) begin
        shft_reg    <= wrt ? tx_data : tx_hold_reg;
        bit_cnt_reg <= '0;
      end else begin
        shft_reg    <= shft_next;
        bit_cnt_reg <= bit_cnt_next;
      end
      if (capture) rx_data <= shft_next;
      frm_err <= err;
      if (capture)      rdy <= 1'b1;
      else if (clr_rdy) rdy <= 1'b0;
    end
  end

  assign MISO = ss_lvl ? 1'bz : shft_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_serf.sv
// Scoreboard bench for spi_serf: a monarch model drives frames and queues the
// expected responses; a monitor pops and compares as the serf produces them.
module tb_spi_serf;

  localparam int HALF = 16;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        SS_n    = 1'b1;
  logic        SCLK    = 1'b1;
  logic        MOSI    = 1'b0;
  logic        wrt     = 1'b0;
  logic        clr_rdy = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  wire         MISO;
  logic        rdy;
  logic        frm_err;
  logic [15:0] rx_data;

  // A released MISO reads as 1 here; hi-z checks are placed where the shift
  // register MSB is 0, so a wrongly driven MISO would read 0.
  pullup (MISO);

  always #5 clk = ~clk;

  spi_serf #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .wrt(wrt), .tx_data(tx_data), .clr_rdy(clr_rdy),
    .rdy(rdy), .rx_data(rx_data), .frm_err(frm_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_rx_q[$];
  logic [15:0] exp_resp_q[$];
  logic [15:0] act_resp_q[$];
  int          exp_err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rdy();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  // Monarch: SCLK half-period of HALF clks, MOSI updated one clk after each
  // rise, MISO sampled one clk after each rise.
  task automatic frame(input logic [15:0] cmd, input int nbits, input bit bypass,
                       input logic [15:0] bypass_word, input bit clr_at_end, input bit abort);
    logic [15:0] resp;
    resp = 16'h0000;
    SS_n = 1'b0;
    MOSI = cmd[15];
    if (bypass) begin
      tick(2);
      wrt     = 1'b1;
      tx_data = bypass_word;
      tick(1);
      wrt = 1'b0;
      tick(13);
    end else begin
      tick(16);
    end
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      tick(HALF);
      SCLK = 1'b1;
      tick(1);
      resp = {resp[14:0], MISO};
      if (i < 15) MOSI = cmd[14-i];
      tick(HALF - 1);
    end
    if (abort) begin
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    if (clr_at_end) begin
      tick(2);
      clr_rdy = 1'b1;
      tick(1);
      clr_rdy = 1'b0;
      tick(6);
    end else begin
      tick(9);
    end
    if (nbits == 16 && !abort) act_resp_q.push_back(resp);
  endtask

  // Monitor / scoreboard
  initial begin
    logic        rdy_prev;
    logic        err_prev;
    logic [15:0] a;
    logic [15:0] e;
    int          tok;
    rdy_prev = 1'b0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy && !rdy_prev) begin
        if (exp_rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rdy: got rx_data %h expected no frame", rx_data);
        end else begin
          e = exp_rx_q.pop_front();
          check("rx_data", {16'h0, rx_data}, {16'h0, e});
        end
      end
      if (frm_err) begin
        if (err_prev) begin
          n_checks++;
          n_fail++;
          $display("FAIL frm_err_width: got pulse longer than 1 clk expected 1 clk");
        end else if (exp_err_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frm_err: got 1 expected 0");
        end else begin
          tok = exp_err_q.pop_front();
          check("frm_err_pulse", {31'h0, frm_err}, 32'h1);
        end
      end
      if (act_resp_q.size() > 0) begin
        a = act_resp_q.pop_front();
        if (exp_resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got %h expected none", a);
        end else begin
          e = exp_resp_q.pop_front();
          check("miso_resp", {16'h0, a}, {16'h0, e});
        end
      end
      rdy_prev = rdy;
      err_prev = frm_err;
    end
  end

  initial begin
    tick(5);
    rst_n = 1'b1;
    tick(5);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_frm_err", {31'h0, frm_err}, 32'h0);
    check("reset_rx_data", {16'h0, rx_data}, 32'h0);
    check("reset_miso_hiz", {31'h0, MISO}, 32'h1);

    // 1: basic full-duplex frame
    tx_data = 16'h1234;
    wrt     = 1'b1;
    tick(1);
    wrt     = 1'b0;
    tx_data = 16'h0000;
    exp_resp_q.push_back(16'h1234);
    exp_rx_q.push_back(16'hA5C3);
    frame(16'hA5C3, 16, 1'b0, 16'h0, 1'b0, 1'b0);
    check("t1_rdy", {31'h0, rdy}, 32'h1);
    clear_rdy();
    check("t1_clr_rdy", {31'h0, rdy}, 32'h0);

    // 3: short frame of 9 bits
    exp_err_q.push_back(3);
    frame(16'h3C3C, 9, 1'b0, 16'h0, 1'b0, 1'b0);
    check("t3_rdy", {31'h0, rdy}, 32'h0);
    check("t3_rx_held", {16'h0, rx_data}, 32'h0000A5C3);

    // 2: clr_rdy coincident with a valid ss_rise; set wins
    exp_resp_q.push_back(16'h1234);
    exp_rx_q.push_back(16'h00FF);
    frame(16'h00FF, 16, 1'b0, 16'h0, 1'b1, 1'b0);
    check("t2_rdy_set_wins", {31'h0, rdy}, 32'h1);
    clear_rdy();
    check("t2_clr_rdy", {31'h0, rdy}, 32'h0);

    // 4: wrt in the same clk as ss_fall bypasses tx_hold
    exp_resp_q.push_back(16'hBEEF);
    exp_rx_q.push_back(16'h0F0F);
    frame(16'h0F0F, 16, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("t4_rdy", {31'h0, rdy}, 32'h1);

    // 5: reset after 8 bits with SS_n held low, then a full frame
    frame(16'hC3C3, 8, 1'b0, 16'h0, 1'b0, 1'b1);
    check("t5_rdy_after_rst", {31'h0, rdy}, 32'h0);
    check("t5_rx_after_rst", {16'h0, rx_data}, 32'h0);
    exp_resp_q.push_back(16'h0000);
    exp_rx_q.push_back(16'h5555);
    frame(16'h5555, 16, 1'b0, 16'h0, 1'b0, 1'b0);
    check("t5_rdy", {31'h0, rdy}, 32'h1);
    check("t5_rx", {16'h0, rx_data}, 32'h00005555);

    // 6: SCLK activity with SS_n high is ignored; tx_hold is reused
    tx_data = 16'hBEEF;
    wrt     = 1'b1;
    tick(1);
    wrt     = 1'b0;
    tx_data = 16'h0000;
    clear_rdy();
    for (int i = 0; i < 20; i++) begin
      SCLK = ~SCLK;
      tick(2);
      if (i % 5 == 4) check("t6_miso_hiz", {31'h0, MISO}, 32'h1);
    end
    tick(4);
    check("t6_rdy", {31'h0, rdy}, 32'h0);
    check("t6_rx_held", {16'h0, rx_data}, 32'h00005555);
    exp_resp_q.push_back(16'hBEEF);
    exp_rx_q.push_back(16'h1111);
    frame(16'h1111, 16, 1'b0, 16'h0, 1'b0, 1'b0);
    clear_rdy();
    exp_resp_q.push_back(16'hBEEF);
    exp_rx_q.push_back(16'h2222);
    frame(16'h2222, 16, 1'b0, 16'h0, 1'b0, 1'b0);
    check("t6_miso_hiz_after", {31'h0, MISO}, 32'h1);

    tick(5);
    check("pending_rx", exp_rx_q.size(), 32'h0);
    check("pending_resp", exp_resp_q.size(), 32'h0);
    check("pending_frm_err", exp_err_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
